// File: rtl/hazard_unit_md_pkg.sv
// hazard_unit_md_pkg: shared encodings and defaults for the hazard unit and the mult/div datapath
package hazard_unit_md_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_W = 2'd1, FWD_M = 2'd2, FWD_E = 2'd3} fwd_e;
  localparam int T_W_DEF = 2;
  localparam logic [T_W_DEF-1:0] TUSE_NONE = '1;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
endpackage

// File: rtl/hazard_unit_md_busy_tracker.sv
// md_busy_tracker: mult/div occupancy counter; ports clk, reset_n, start_i, div_i (divide select), busy_o
module md_busy_tracker
  import hazard_unit_md_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // a start seen while already busy is dropped; the D-stage interlock keeps it from happening
  always_comb cnt_d = cnt_q != '0 ? cnt_q - CW'(1) : start_i ? (div_i ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES)) : '0;
  always_ff @(posedge clk)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign busy_o = cnt_q != '0;
endmodule

// File: rtl/hazard_unit_md.sv
// hazard_unit_md: Tuse/Tnew forwarding, stall and HI/LO interlock for a 5-stage MIPS pipeline
//   in : D_rs/D_rt + tuse, D_md, E_rs/E_rt, M_rt, per-stage wa/we, E/M tnew, E_md_start/E_md_div
//   out: stall, E_clr, D/E/M forwarding selects, md_busy, saturating stall_cnt
module hazard_unit_md
  import hazard_unit_md_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int T_W        = T_W_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [RA_W-1:0] D_rs,
  input  logic [RA_W-1:0] D_rt,
  input  logic [T_W-1:0]  D_tuse_rs,
  input  logic [T_W-1:0]  D_tuse_rt,
  input  logic            D_md,
  input  logic [RA_W-1:0] E_rs,
  input  logic [RA_W-1:0] E_rt,
  input  logic [RA_W-1:0] M_rt,
  input  logic [RA_W-1:0] E_wa,
  input  logic [RA_W-1:0] M_wa,
  input  logic [RA_W-1:0] W_wa,
  input  logic            E_we,
  input  logic            M_we,
  input  logic            W_we,
  input  logic [T_W-1:0]  E_tnew,
  input  logic [T_W-1:0]  M_tnew,
  input  logic            E_md_start,
  input  logic            E_md_div,
  output logic            stall,
  output logic            E_clr,
  output logic [1:0]      D_rs_fwd,
  output logic [1:0]      D_rt_fwd,
  output logic [1:0]      E_rs_fwd,
  output logic [1:0]      E_rt_fwd,
  output logic            M_rt_fwd,
  output logic            md_busy,
  output logic [CNT_W-1:0] stall_cnt
);
  function automatic logic hit(input logic we, input logic [RA_W-1:0] wa, input logic [RA_W-1:0] a);
    return we && wa != '0 && wa == a;
  endfunction
  logic e_drs, m_drs, w_drs, e_drt, m_drt, w_drt, m_ers, w_ers, m_ert, w_ert;
  logic rs_stall, rt_stall, md_stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  assign e_drs = hit(E_we, E_wa, D_rs);
  assign m_drs = hit(M_we, M_wa, D_rs);
  assign w_drs = hit(W_we, W_wa, D_rs);
  assign e_drt = hit(E_we, E_wa, D_rt);
  assign m_drt = hit(M_we, M_wa, D_rt);
  assign w_drt = hit(W_we, W_wa, D_rt);
  assign m_ers = hit(M_we, M_wa, E_rs);
  assign w_ers = hit(W_we, W_wa, E_rs);
  assign m_ert = hit(M_we, M_wa, E_rt);
  assign w_ert = hit(W_we, W_wa, E_rt);
  // nearest producer owns the register; if it is not ready yet, fall back to RF and let the stall cover it
  assign D_rs_fwd = e_drs ? (E_tnew == '0 ? FWD_E : FWD_RF) : m_drs ? (M_tnew == '0 ? FWD_M : FWD_RF) : w_drs ? FWD_W : FWD_RF;
  assign D_rt_fwd = e_drt ? (E_tnew == '0 ? FWD_E : FWD_RF) : m_drt ? (M_tnew == '0 ? FWD_M : FWD_RF) : w_drt ? FWD_W : FWD_RF;
  assign E_rs_fwd = m_ers ? (M_tnew == '0 ? FWD_M : FWD_RF) : w_ers ? FWD_W : FWD_RF;
  assign E_rt_fwd = m_ert ? (M_tnew == '0 ? FWD_M : FWD_RF) : w_ert ? FWD_W : FWD_RF;
  assign M_rt_fwd = hit(W_we, W_wa, M_rt);
  // all-ones tuse marks an operand that is never read
  assign rs_stall = ~&D_tuse_rs && ((e_drs && E_tnew > D_tuse_rs) || (m_drs && M_tnew > D_tuse_rs));
  assign rt_stall = ~&D_tuse_rt && ((e_drt && E_tnew > D_tuse_rt) || (m_drt && M_tnew > D_tuse_rt));
  assign md_stall = D_md && (md_busy || E_md_start);
  assign stall = rs_stall || rt_stall || md_stall;
  assign E_clr = stall;
  md_busy_tracker #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk    (clk),
    .reset_n(reset_n),
    .start_i(E_md_start),
    .div_i  (E_md_div),
    .busy_o (md_busy)
  );
  always_comb stall_cnt_d = stall && !(&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  always_ff @(posedge clk)
    if (!reset_n) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_unit_md.sv
// tb_hazard_unit_md: directed and randomized checks of hazard_unit_md against a rule-level model
module tb_hazard_unit_md;
  logic clk = 0;
  logic reset_n;
  logic [4:0] D_rs, D_rt, E_rs, E_rt, M_rt, E_wa, M_wa, W_wa;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic D_md, E_we, M_we, W_we, E_md_start, E_md_div;
  logic stall, E_clr, M_rt_fwd, md_busy;
  logic [1:0] D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd;
  logic [31:0] stall_cnt;
  logic s_stall, s_clr, s_mrt, s_busy;
  logic [1:0] s_drs, s_drt, s_ers, s_ert;
  logic [3:0] s_cnt;
  int n_chk = 0, n_fail = 0;
  int md_rem;
  longint sc;

  always #5 clk = ~clk;

  hazard_unit_md dut (
    .clk(clk), .reset_n(reset_n), .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_md(D_md), .E_rs(E_rs), .E_rt(E_rt), .M_rt(M_rt), .E_wa(E_wa), .M_wa(M_wa), .W_wa(W_wa),
    .E_we(E_we), .M_we(M_we), .W_we(W_we), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div), .stall(stall), .E_clr(E_clr),
    .D_rs_fwd(D_rs_fwd), .D_rt_fwd(D_rt_fwd), .E_rs_fwd(E_rs_fwd), .E_rt_fwd(E_rt_fwd),
    .M_rt_fwd(M_rt_fwd), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  hazard_unit_md #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_md(D_md), .E_rs(E_rs), .E_rt(E_rt), .M_rt(M_rt), .E_wa(E_wa), .M_wa(M_wa), .W_wa(W_wa),
    .E_we(E_we), .M_we(M_we), .W_we(W_we), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div), .stall(s_stall), .E_clr(s_clr),
    .D_rs_fwd(s_drs), .D_rt_fwd(s_drt), .E_rs_fwd(s_ers), .E_rt_fwd(s_ert),
    .M_rt_fwd(s_mrt), .md_busy(s_busy), .stall_cnt(s_cnt)
  );

  // stage 0=E, 1=M, 2=W; forwarding code of stage s is 3-s
  function automatic logic ref_hit(input int s, input logic [4:0] a);
    logic w;
    logic [4:0] r;
    w = s == 0 ? E_we : s == 1 ? M_we : W_we;
    r = s == 0 ? E_wa : s == 1 ? M_wa : W_wa;
    return w && r != 0 && r == a;
  endfunction
  function automatic int ref_tnew(input int s);
    return s == 0 ? int'(E_tnew) : s == 1 ? int'(M_tnew) : 0;
  endfunction
  function automatic logic [1:0] ref_fwd(input logic [4:0] a, input int first);
    for (int s = first; s < 3; s++) if (ref_hit(s, a)) return ref_tnew(s) == 0 ? 2'(3 - s) : 2'd0;
    return 2'd0;
  endfunction
  function automatic logic ref_dstall(input logic [4:0] a, input logic [1:0] tu);
    if (tu == 2'd3) return 1'b0;
    for (int s = 0; s < 2; s++) if (ref_hit(s, a) && ref_tnew(s) > int'(tu)) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic ref_stall();
    return ref_dstall(D_rs, D_tuse_rs) || ref_dstall(D_rt, D_tuse_rt) || (D_md && (md_rem > 0 || E_md_start));
  endfunction
  function automatic longint sat(input longint v, input longint mx);
    return v > mx ? mx : v;
  endfunction

  always @(posedge clk)
    if (!reset_n) begin
      md_rem <= 0;
      sc <= 0;
    end else begin
      md_rem <= md_rem > 0 ? md_rem - 1 : E_md_start ? (E_md_div ? 10 : 5) : 0;
      if (ref_stall()) sc <= sc + 1;
    end

  task automatic clr();
    {D_rs, D_rt, E_rs, E_rt, M_rt, E_wa, M_wa, W_wa} = '0;
    {D_tuse_rs, D_tuse_rt, E_tnew, M_tnew} = '0;
    {D_md, E_we, M_we, W_we, E_md_start, E_md_div} = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 0;
    clr();
    step();
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 0;
    step();
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0d want 0", stall); end
    n_chk++; if (E_clr !== 1'b0) begin n_fail++; $display("FAIL rst_eclr got %0d want 0", E_clr); end
    n_chk++; if ({D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd} !== 9'd0) begin n_fail++; $display("FAIL rst_fwd got %0h want 0", {D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd}); end
    n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0d want 0", md_busy); end
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", stall_cnt); end
    n_chk++; if (s_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt4 got %0d want 0", s_cnt); end
    reset_n = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    E_wa = 1; E_we = 1; E_tnew = 2; D_rs = 1; D_rt = 2;
    @(negedge clk);
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_e_stall got %0d want 1", stall); end
    n_chk++; if (E_clr !== 1'b1) begin n_fail++; $display("FAIL lu_e_clr got %0d want 1", E_clr); end
    n_chk++; if (D_rs_fwd !== 2'd0) begin n_fail++; $display("FAIL lu_e_fwd got %0d want 0", D_rs_fwd); end
    step();
    E_we = 0; E_wa = 0; E_tnew = 0; M_wa = 1; M_we = 1; M_tnew = 1;
    @(negedge clk);
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_m_stall got %0d want 1", stall); end
    step();
    M_we = 0; M_wa = 0; M_tnew = 0; W_wa = 1; W_we = 1;
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_w_stall got %0d want 0", stall); end
    n_chk++; if (D_rs_fwd !== 2'd1) begin n_fail++; $display("FAIL lu_w_fwd got %0d want 1", D_rs_fwd); end
    n_chk++; if (stall_cnt !== 32'd2) begin n_fail++; $display("FAIL lu_cnt got %0d want 2", stall_cnt); end
  endtask

  task automatic test_forward_alu();
    do_reset();
    M_wa = 3; M_we = 1; D_rs = 3; D_tuse_rs = 1; D_tuse_rt = 1;
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_m_stall got %0d want 0", stall); end
    n_chk++; if (D_rs_fwd !== 2'd2) begin n_fail++; $display("FAIL alu_m_fwd got %0d want 2", D_rs_fwd); end
    E_wa = 3; E_we = 1; E_tnew = 1;
    @(negedge clk);
    n_chk++; if (D_rs_fwd !== 2'd0) begin n_fail++; $display("FAIL alu_shadow got %0d want 0", D_rs_fwd); end
    step();
    M_we = 0; M_wa = 0;
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_e_stall got %0d want 0", stall); end
    step();
    E_we = 0; E_wa = 0; E_tnew = 0; M_wa = 3; M_we = 1; E_rs = 3; E_rt = 3; W_wa = 5; W_we = 1; M_rt = 5;
    @(negedge clk);
    n_chk++; if (E_rs_fwd !== 2'd2) begin n_fail++; $display("FAIL alu_ers_fwd got %0d want 2", E_rs_fwd); end
    n_chk++; if (M_rt_fwd !== 1'b1) begin n_fail++; $display("FAIL alu_mrt_fwd got %0d want 1", M_rt_fwd); end
    M_tnew = 1;
    @(negedge clk);
    n_chk++; if (E_rt_fwd !== 2'd0) begin n_fail++; $display("FAIL alu_ert_notready got %0d want 0", E_rt_fwd); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    E_wa = 0; E_we = 1; E_tnew = 2; D_rs = 0; M_wa = 0; M_we = 1; W_wa = 0; W_we = 1;
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall got %0d want 0", stall); end
    n_chk++; if (D_rs_fwd !== 2'd0) begin n_fail++; $display("FAIL zero_fwd got %0d want 0", D_rs_fwd); end
    D_tuse_rs = 3; E_wa = 7; D_rs = 7;
    @(negedge clk);
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL tuse_none_stall got %0d want 0", stall); end
  endtask

  task automatic test_md(input bit div);
    int n;
    n = div ? 10 : 5;
    do_reset();
    E_md_start = 1; E_md_div = div; D_md = 1;
    @(negedge clk);
    n_chk++; if (stall !== 1'b1 || md_busy !== 1'b0) begin n_fail++; $display("FAIL md_issue div=%0d got stall=%0d busy=%0d want 1 0", div, stall, md_busy); end
    step();
    E_md_start = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      n_chk++; if (stall !== 1'b1 || md_busy !== 1'b1) begin n_fail++; $display("FAIL md_busy div=%0d cyc=%0d got stall=%0d busy=%0d want 1 1", div, i, stall, md_busy); end
      step();
    end
    @(negedge clk);
    n_chk++; if (stall !== 1'b0 || md_busy !== 1'b0) begin n_fail++; $display("FAIL md_done div=%0d got stall=%0d busy=%0d want 0 0", div, stall, md_busy); end
    n_chk++; if (stall_cnt !== 32'(n + 1)) begin n_fail++; $display("FAIL md_cnt div=%0d got %0d want %0d", div, stall_cnt, n + 1); end
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    E_md_start = 1; E_md_div = 1; D_md = 1;
    step();
    E_md_start = 0;
    repeat (3) step();
    @(negedge clk);
    n_chk++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL mid_pre_cnt got %0d want 4", stall_cnt); end
    reset_n = 0;
    step();
    reset_n = 1;
    @(negedge clk);
    n_chk++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %0d want 0", md_busy); end
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", stall_cnt); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_mflo_stall got %0d want 0", stall); end
  endtask

  task automatic test_saturation();
    do_reset();
    E_wa = 1; E_we = 1; E_tnew = 2; D_rs = 1; D_md = 1; E_md_start = 1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      n_chk++; if (s_cnt !== 4'(i > 15 ? 15 : i)) begin n_fail++; $display("FAIL sat_cnt4 cyc=%0d got %0d want %0d", i, s_cnt, i > 15 ? 15 : i); end
      n_chk++; if (stall_cnt !== 32'(i)) begin n_fail++; $display("FAIL sat_cnt32 cyc=%0d got %0d want %0d", i, stall_cnt, i); end
      step();
    end
  endtask

  task automatic test_random();
    logic [11:0] exp_v;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      reset_n = $urandom_range(0, 39) != 0;
      D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
      E_rs = 5'($urandom_range(0, 3)); E_rt = 5'($urandom_range(0, 3)); M_rt = 5'($urandom_range(0, 3));
      E_wa = 5'($urandom_range(0, 3)); M_wa = 5'($urandom_range(0, 3)); W_wa = 5'($urandom_range(0, 3));
      D_tuse_rs = 2'($urandom); D_tuse_rt = 2'($urandom); E_tnew = 2'($urandom); M_tnew = 2'($urandom_range(0, 1));
      {E_we, M_we, W_we} = 3'($urandom);
      D_md = $urandom_range(0, 2) == 0; E_md_start = $urandom_range(0, 3) == 0; E_md_div = 1'($urandom);
      @(negedge clk);
      exp_v = {ref_stall(), ref_stall(), ref_fwd(D_rs, 0), ref_fwd(D_rt, 0), ref_fwd(E_rs, 1), ref_fwd(E_rt, 1), ref_fwd(M_rt, 2) != 0, md_rem > 0};
      n_chk++; if ({stall, E_clr, D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd, md_busy} !== exp_v) begin n_fail++; $display("FAIL rnd_outs cyc=%0d got %03h want %03h", i, {stall, E_clr, D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd, md_busy}, exp_v); end
      n_chk++; if ({s_stall, s_clr, s_drs, s_drt, s_ers, s_ert, s_mrt, s_busy} !== exp_v) begin n_fail++; $display("FAIL rnd_outs4 cyc=%0d got %03h want %03h", i, {s_stall, s_clr, s_drs, s_drt, s_ers, s_ert, s_mrt, s_busy}, exp_v); end
      n_chk++; if (stall_cnt !== 32'(sat(sc, 64'hFFFF_FFFF))) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got %0d want %0d", i, stall_cnt, sat(sc, 64'hFFFF_FFFF)); end
      n_chk++; if (s_cnt !== 4'(sat(sc, 15))) begin n_fail++; $display("FAIL rnd_cnt4 cyc=%0d got %0d want %0d", i, s_cnt, sat(sc, 15)); end
      step();
    end
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    clr();
    test_reset();
    test_load_use();
    test_forward_alu();
    test_zero_reg();
    test_md(1'b1);
    test_md(1'b0);
    test_reset_mid_div();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
